sqrt_fixed_iter: RTL and testbench

SQRT_FIXED_ITER -- requirements
Module: sqrt_fixed_iter

---
 rtl/sqrt_pkg.sv | 30 +++
 rtl/sqrt_fixed_iter.sv | 117 +++++++++++
 tb/tb_sqrt_fixed_iter.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sqrt_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sqrt_pkg : shared fixed-point constants, root FSM states, width helpers     |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
package sqrt_pkg;

  localparam int SQRT_DEF_IN_W   = 12;
  localparam int SQRT_DEF_IN_FB  = 4;
  localparam int SQRT_DEF_OUT_FB = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } sqrt_state_e;

  // Aligned radicand width, padded to an even count so it splits into digit pairs.
  function automatic int calc_rw(input int in_w, input int in_fb, input int out_fb);
    int w;
    w = in_w + 2 * out_fb - in_fb;
    return w + (w % 2);
  endfunction

  function automatic int calc_qw(input int in_w, input int in_fb, input int out_fb);
    return calc_rw(in_w, in_fb, out_fb) / 2;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sqrt_fixed_iter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sqrt_fixed_iter : fixed-point square root, one root bit per cycle           |
// |                   (non-restoring digit recurrence, fixed latency)           |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
module sqrt_fixed_iter
  import sqrt_pkg::*;
#(
  parameter int IN_W   = SQRT_DEF_IN_W,
  parameter int IN_FB  = SQRT_DEF_IN_FB,
  parameter int OUT_FB = SQRT_DEF_OUT_FB
) (
  input  logic                                     clk,
  input  logic                                     rst_,
  input  logic                                     in_valid,
  output logic                                     in_ready,
  input  logic [IN_W-1:0]                          a,
  output logic                                     out_valid,
  input  logic                                     out_ready,
  output logic [calc_qw(IN_W, IN_FB, OUT_FB)-1:0]  q,
  output logic [calc_qw(IN_W, IN_FB, OUT_FB):0]    rem,
  output logic                                     exact,
  output logic                                     busy
);

  localparam int RW = calc_rw(IN_W, IN_FB, OUT_FB);
  localparam int QW = RW / 2;
  localparam int SH = 2 * OUT_FB - IN_FB;
  localparam int IW = (QW > 1) ? $clog2(QW) : 1;

  sqrt_state_e          r_state;
  sqrt_state_e          w_state_nx;
  logic [RW-1:0]        r_rad;
  logic [QW-1:0]        r_root;
  logic signed [QW+1:0] r_rem;
  logic [IW-1:0]        r_iter;

  logic                 w_accept;
  logic                 w_last;
  logic [RW-1:0]        w_rad_in;
  logic signed [QW+1:0] w_rem_sh;
  logic signed [QW+1:0] w_rem_step;
  logic signed [QW+1:0] w_rem_fix;
  logic [QW-1:0]        w_root_step;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) r_state <= ST_IDLE;
    else       r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nx = ST_CALC;
      end
      ST_CALC: begin
        busy = 1'b1;
        if (r_iter == '0) w_state_nx = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nx = ST_IDLE;
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  assign w_accept = in_ready & in_valid;
  assign w_last   = busy & (r_iter == '0);

  // Recurrence step: bring in the next digit pair, then subtract or add the trial
  // term depending on the sign of the running remainder.
  always_comb begin
    w_rad_in = RW'(a) << SH;
    w_rem_sh = (r_rem << 2) | {{QW{1'b0}}, r_rad[RW-1 -: 2]};
    if (r_rem[QW+1]) w_rem_step = w_rem_sh + {r_root, 2'b11};
    else             w_rem_step = w_rem_sh - {r_root, 2'b01};
    w_root_step = {r_root[QW-2:0], ~w_rem_step[QW+1]};
    if (w_rem_step[QW+1]) w_rem_fix = w_rem_step + {1'b0, w_root_step, 1'b1};
    else                  w_rem_fix = w_rem_step;
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_rad  <= '0;
      r_root <= '0;
      r_rem  <= '0;
      r_iter <= '0;
      q      <= '0;
      rem    <= '0;
      exact  <= 1'b0;
    end else if (w_accept) begin
      r_rad  <= w_rad_in;
      r_root <= '0;
      r_rem  <= '0;
      r_iter <= IW'(QW - 1);
    end else if (busy) begin
      r_rad  <= r_rad << 2;
      r_root <= w_root_step;
      r_rem  <= w_rem_step;
      r_iter <= r_iter - 1'b1;
      if (w_last) begin
        q     <= w_root_step;
        rem   <= w_rem_fix[QW:0];
        exact <= (w_rem_fix == '0);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sqrt_fixed_iter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_sqrt_fixed_iter : randomized check of two root configurations against an |
// |                      integer square-root model                              |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_sqrt_fixed_iter;

  // Config A: 12.4 in, 16 frac out -> RW 40, QW 20, shift 28.
  // Config B: 16 bits, 8 frac in, 8 frac out -> RW 24, QW 12, shift 8.
  localparam int A_QW   = 20;
  localparam int A_SH   = 28;
  localparam int B_QW   = 12;
  localparam int B_SH   = 8;
  localparam int N_RAND = 1500;

  logic clk  = 1'b0;
  logic rst_ = 1'b0;

  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_exact, a_busy;
  logic [11:0] a_a;
  logic [19:0] a_q;
  logic [20:0] a_rem;

  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_exact, b_busy;
  logic [15:0] b_a;
  logic [11:0] b_q;
  logic [12:0] b_rem;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  sqrt_fixed_iter #(.IN_W(12), .IN_FB(4), .OUT_FB(16)) u_dut_a (
    .clk(clk), .rst_(rst_), .in_valid(a_in_valid), .in_ready(a_in_ready), .a(a_a),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .q(a_q), .rem(a_rem),
    .exact(a_exact), .busy(a_busy)
  );

  sqrt_fixed_iter #(.IN_W(16), .IN_FB(8), .OUT_FB(8)) u_dut_b (
    .clk(clk), .rst_(rst_), .in_valid(b_in_valid), .in_ready(b_in_ready), .a(b_a),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .q(b_q), .rem(b_rem),
    .exact(b_exact), .busy(b_busy)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] o_q(input int s);
    return s != 0 ? 64'(b_q) : 64'(a_q);
  endfunction
  function automatic logic [63:0] o_rem(input int s);
    return s != 0 ? 64'(b_rem) : 64'(a_rem);
  endfunction
  function automatic logic o_exact(input int s);
    return s != 0 ? b_exact : a_exact;
  endfunction
  function automatic logic o_ov(input int s);
    return s != 0 ? b_out_valid : a_out_valid;
  endfunction
  function automatic logic o_ir(input int s);
    return s != 0 ? b_in_ready : a_in_ready;
  endfunction
  function automatic logic o_busy(input int s);
    return s != 0 ? b_busy : a_busy;
  endfunction

  task automatic drive(input int s, input logic v, input logic [15:0] x);
    if (s != 0) begin b_in_valid = v; b_a = x; end
    else begin a_in_valid = v; a_a = x[11:0]; end
  endtask

  task automatic set_ordy(input int s, input logic v);
    if (s != 0) b_out_ready = v;
    else        a_out_ready = v;
  endtask

  function automatic logic [63:0] isqrt(input logic [63:0] r);
    logic [63:0] lo, hi, mid;
    lo = 0;
    hi = 64'd1 << 24;
    while (lo < hi) begin
      mid = (lo + hi + 1) >> 1;
      if (mid * mid <= r) lo = mid;
      else hi = mid - 1;
    end
    return lo;
  endfunction

  // One transaction: offer x, keep in_valid high with junk data during CALC,
  // optionally stall the consumer for 'hold' cycles, then retire the result.
  task automatic run_op(input int s, input logic [15:0] x, input int hold,
                        output logic [63:0] q, output logic [63:0] rem,
                        output logic ex, output int lat);
    int n;
    q = 0; rem = 0; ex = 1'b0; lat = -1;
    @(negedge clk);
    drive(s, 1'b1, x);
    n = 0;
    while (!o_ir(s) && n < 100) begin @(negedge clk); n++; end
    if (!o_ir(s)) begin
      chk("accept_timeout", 0, 1);
      drive(s, 1'b0, 16'h0);
      return;
    end
    @(posedge clk);
    @(negedge clk);
    drive(s, 1'b1, 16'($urandom));
    lat = 1;
    chk("busy", 64'(o_busy(s)), 1);
    n = 0;
    while (!o_ov(s) && n < 200) begin
      @(posedge clk); @(negedge clk);
      drive(s, 1'b1, 16'($urandom));
      lat++; n++;
    end
    drive(s, 1'b0, 16'h0);
    if (!o_ov(s)) begin
      chk("done_timeout", 0, 1);
      return;
    end
    q   = o_q(s);
    rem = o_rem(s);
    ex  = o_exact(s);
    for (int i = 0; i < hold; i++) begin
      drive(s, 1'b1, 16'($urandom));
      @(posedge clk); @(negedge clk);
      chk("hold_q", o_q(s), q);
      chk("hold_rem", o_rem(s), rem);
      chk("hold_exact", 64'(o_exact(s)), 64'(ex));
      chk("hold_valid", 64'(o_ov(s)), 1);
      chk("hold_in_ready", 64'(o_ir(s)), 0);
    end
    drive(s, 1'b0, 16'h0);
    set_ordy(s, 1'b1);
    if (hold > 0) chk("leave_in_ready", 64'(o_ir(s)), 0);
    @(posedge clk); @(negedge clk);
    set_ordy(s, 1'b0);
    if (hold > 0) chk("after_leave_valid", 64'(o_ov(s)), 0);
  endtask

  task automatic check_model(input int s, input logic [15:0] x, input logic [63:0] q,
                             input logic [63:0] rem, input logic ex, input int lat);
    logic [63:0] r, qr;
    r  = 64'(x) << (s != 0 ? B_SH : A_SH);
    qr = isqrt(r);
    chk(s != 0 ? "b_q" : "a_q", q, qr);
    chk(s != 0 ? "b_rem" : "a_rem", rem, r - qr * qr);
    chk(s != 0 ? "b_exact" : "a_exact", 64'(ex), 64'(r == qr * qr));
    chk(s != 0 ? "b_lat" : "a_lat", 64'(lat), 64'((s != 0 ? B_QW : A_QW) + 1));
  endtask

  typedef struct { logic [15:0] x; logic [63:0] q; logic [63:0] r; logic e; } dir_t;

  initial begin
    dir_t        dirs[4];
    logic [63:0] q, rem;
    logic        ex;
    int          lat;

    a_in_valid = 0; a_out_ready = 0; a_a = '0;
    b_in_valid = 0; b_out_ready = 0; b_a = '0;

    #12;
    chk("rst_in_ready", 64'(a_in_ready), 1);
    chk("rst_out_valid", 64'(a_out_valid), 0);
    chk("rst_busy", 64'(a_busy), 0);
    chk("rst_q", 64'(a_q), 0);
    chk("rst_rem", 64'(a_rem), 0);
    chk("rst_exact", 64'(a_exact), 0);
    chk("rst_b_in_ready", 64'(b_in_ready), 1);
    @(negedge clk);
    rst_ = 1'b1;

    dirs[0] = '{16'h100, 64'h40000, 64'd0, 1'b1};
    dirs[1] = '{16'h020, 64'd92681, 64'd166831, 1'b0};
    dirs[2] = '{16'h001, 64'h04000, 64'd0, 1'b1};
    dirs[3] = '{16'h000, 64'd0, 64'd0, 1'b1};
    foreach (dirs[i]) begin
      run_op(0, dirs[i].x, 0, q, rem, ex, lat);
      chk("dir_q", q, dirs[i].q);
      chk("dir_rem", rem, dirs[i].r);
      chk("dir_exact", 64'(ex), 64'(dirs[i].e));
      chk("dir_lat", 64'(lat), 21);
    end

    run_op(0, 16'h020, 10, q, rem, ex, lat);
    chk("stall_q", q, 64'd92681);
    chk("stall_rem", rem, 64'd166831);

    // Reset pulse in the middle of a computation, off the clock edge.
    @(negedge clk);
    drive(0, 1'b1, 16'h020);
    @(posedge clk);
    @(negedge clk);
    drive(0, 1'b0, 16'h0);
    repeat (6) @(posedge clk);
    #2;
    rst_ = 1'b0;
    #1;
    chk("arst_in_ready", 64'(a_in_ready), 1);
    chk("arst_out_valid", 64'(a_out_valid), 0);
    chk("arst_busy", 64'(a_busy), 0);
    chk("arst_q", 64'(a_q), 0);
    chk("arst_rem", 64'(a_rem), 0);
    chk("arst_exact", 64'(a_exact), 0);
    @(negedge clk);
    rst_ = 1'b1;
    run_op(0, 16'h100, 0, q, rem, ex, lat);
    chk("post_rst_q", q, 64'h40000);
    chk("post_rst_lat", 64'(lat), 21);

    run_op(0, 16'h0FFF, 0, q, rem, ex, lat);
    check_model(0, 16'h0FFF, q, rem, ex, lat);
    run_op(1, 16'hFFFF, 0, q, rem, ex, lat);
    check_model(1, 16'hFFFF, q, rem, ex, lat);

    fork
      begin
        logic [15:0] xa;
        logic [63:0] qa, ra;
        logic        ea;
        int          la;
        for (int i = 0; i < N_RAND; i++) begin
          xa = 16'($urandom_range(0, 4095));
          run_op(0, xa, 0, qa, ra, ea, la);
          check_model(0, xa, qa, ra, ea, la);
        end
      end
      begin
        logic [15:0] xb;
        logic [63:0] qb, rb;
        logic        eb;
        int          lb;
        for (int j = 0; j < N_RAND; j++) begin
          xb = 16'($urandom_range(0, 65535));
          run_op(1, xb, 0, qb, rb, eb, lb);
          check_model(1, xb, qb, rb, eb, lb);
        end
      end
    join

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
